wb_interconnect_arb: RTL and testbench

WB_INTERCONNECT_ARB -- requirements
Module: wb_interconnect_arb

---
 rtl/wb_icon_pkg.sv | 24 ++
 rtl/wb_if.sv | 9 +
 rtl/wb_rr_arbiter.sv | 40 ++++
 rtl/wb_interconnect_arb.sv | 150 +++++++++++++++
 tb/tb_wb_interconnect_arb.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_icon_pkg.sv
// Shared types and the address-decode helper for the Wishbone interconnect.
package wb_icon_pkg;

  typedef enum logic {FIXED = 1'b0, RR = 1'b1} arb_mode_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  // 33-bit compare so a region ending at 2^32 does not wrap to zero
  function automatic logic addr_hit(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input logic [31:0] size);
    logic [32:0] lo, hi;
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return ({1'b0, adr} >= lo) && ({1'b0, adr} < hi);
  endfunction

endpackage

// File: rtl/wb_if.sv
// 32-bit classic Wishbone bundle; master drives the request, slave the response.
interface wb_if;
  logic        cyc, stb, we, ack, err;
  logic [3:0]  sel;
  logic [31:0] adr, dat_m, dat_s;

  modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack, err);
endinterface

// File: rtl/wb_rr_arbiter.sv
// One-hot request arbiter: fixed priority (lowest index) or round-robin from last winner.
module wb_rr_arbiter
  import wb_icon_pkg::*;
#(
  parameter int NUMM = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  arb_mode_e       mode,
  input  logic [NUMM-1:0] req,
  input  logic            take,
  output logic [NUMM-1:0] gnt
);
  localparam int LW = (NUMM > 1) ? $clog2(NUMM) : 1;

  logic [LW-1:0] last_q, idx, gnt_idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = last_q;
    found   = 1'b0;
    idx     = '0;
    for (int o = 1; o <= NUMM; o++) begin
      idx = (mode == FIXED) ? LW'(o - 1) : LW'((int'(last_q) + o) % NUMM);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  // reset points last at NUMM-1 so master 0 is searched first
  always_ff @(posedge clk) begin
    if (rst)                last_q <= LW'(NUMM - 1);
    else if (take && found) last_q <= gnt_idx;
  end

endmodule

// File: rtl/wb_interconnect_arb.sv
// NUMM-master / NUMS-slave classic Wishbone shared-bus interconnect with address decode.
// Optional slave-response watchdog: define WB_ICON_TIMEOUT_EN.
module wb_interconnect_arb
  import wb_icon_pkg::*;
#(
  parameter int                 NUMM      = 3,
  parameter int                 NUMS      = 3,
  parameter logic [NUMS*32-1:0] BASE_ADDR = {32'h1A11_0000, 32'h0000_0000, 32'h1000_0000},
  parameter logic [NUMS*32-1:0] SIZE      = {32'h0000_1000, 32'h0001_0000, 32'h0000_1000},
  parameter arb_mode_e          ARB_MODE  = RR,
  parameter int                 TIMEOUT   = 255
) (
  input logic  clk,
  input logic  rst,
  wb_if.slave  wbm [NUMM],
  wb_if.master wbs [NUMS]
);
  if (NUMM < 1 || NUMM > 8 || NUMS < 1 || NUMS > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("wb_interconnect_arb: parameter out of range");
  end

  wb_req_t [NUMM-1:0]       m_req;
  logic    [NUMM-1:0]       m_cyc, m_stb, arb_gnt, gnt_q, gnt_nxt;
  logic    [NUMS-1:0]       s_ack, s_err, hit;
  logic    [NUMS-1:0][31:0] s_dat;
  arb_state_e               state, state_nxt;
  wb_req_t                  g_req;
  logic                     g_cyc, g_stb, any_hit, act_cyc, act, arb_take, miss_q, to_err;
  logic                     sel_ack, sel_err, resp_ack, resp_err;
  logic    [31:0]           sel_dat;

  for (genvar i = 0; i < NUMM; i++) begin : g_m
    assign m_cyc[i]     = wbm[i].cyc;
    assign m_stb[i]     = wbm[i].stb;
    assign m_req[i]     = {wbm[i].we, wbm[i].sel, wbm[i].adr, wbm[i].dat_m};
    assign wbm[i].ack   = gnt_q[i] & resp_ack;
    assign wbm[i].err   = gnt_q[i] & resp_err;
    assign wbm[i].dat_s = sel_dat;
  end

  for (genvar k = 0; k < NUMS; k++) begin : g_s
    assign wbs[k].cyc   = act_cyc & hit[k];
    assign wbs[k].stb   = act & hit[k] & ~to_err;
    assign wbs[k].we    = g_req.we;
    assign wbs[k].sel   = g_req.sel;
    assign wbs[k].adr   = g_req.adr;
    assign wbs[k].dat_m = g_req.dat;
    assign s_ack[k]     = wbs[k].ack;
    assign s_err[k]     = wbs[k].err;
    assign s_dat[k]     = wbs[k].dat_s;
  end

  wb_rr_arbiter #(.NUMM(NUMM)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .mode (ARB_MODE),
    .req  (m_cyc),
    .take (arb_take),
    .gnt  (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    arb_take  = 1'b0;
    case (state)
      IDLE: if (|m_cyc) begin
        state_nxt = BUSY;
        gnt_nxt   = arb_gnt;
        arb_take  = 1'b1;
      end
      BUSY: if (!g_cyc) begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    g_req = '0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int i = 0; i < NUMM; i++)
      if (gnt_q[i]) begin
        g_req = m_req[i];
        g_cyc = m_cyc[i];
        g_stb = m_stb[i];
      end
  end

  // lowest matching slave wins on overlap
  always_comb begin
    hit     = '0;
    any_hit = 1'b0;
    for (int k = 0; k < NUMS; k++)
      if (!any_hit && addr_hit(g_req.adr, BASE_ADDR[(NUMS-1-k)*32 +: 32], SIZE[(NUMS-1-k)*32 +: 32])) begin
        hit[k]  = 1'b1;
        any_hit = 1'b1;
      end
  end

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NUMS; k++)
      if (hit[k]) begin
        sel_ack = s_ack[k];
        sel_err = s_err[k];
        sel_dat = s_dat[k];
      end
  end

  // rst gates the bus immediately so an aborted access never completes
  assign act_cyc  = (state == BUSY) & g_cyc & ~rst;
  assign act      = act_cyc & g_stb;
  assign resp_ack = act & sel_ack & ~sel_err & ~to_err;
  assign resp_err = act & (sel_err | miss_q | to_err);

  // unmapped access: one-cycle err the cycle after stb is seen
  always_ff @(posedge clk) begin
    if (rst) miss_q <= 1'b0;
    else     miss_q <= act & ~any_hit & ~miss_q;
  end

`ifdef WB_ICON_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign to_err = act & any_hit & (wd_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || !act || !any_hit || sel_ack || sel_err || to_err) wd_cnt <= '0;
    else                                                       wd_cnt <= wd_cnt + 16'd1;
  end
`else
  assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_interconnect_arb.sv
// Scoreboard bench: 3 masters, 3 responder slaves, default address map, round-robin DUT.
module tb_wb_interconnect_arb;
  import wb_icon_pkg::*;

  typedef struct { int m; logic err; logic [31:0] dat; } exp_t;
  typedef struct { int m; logic [31:0] adr; logic we; logic [2:0] sc; logic err; logic [31:0] dat; } row_t;

  localparam logic [31:0] SDAT [3] = '{32'h1111_0000, 32'h2222_0000, 32'hA5A5_A5A5};

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  wb_if wbm_if [3] ();
  wb_if wbs_if [3] ();

  logic [2:0]  m_cyc, m_stb, m_we, m_ack, m_err;
  logic [3:0]  m_sel [3];
  logic [31:0] m_adr [3], m_dat_m [3], m_dat_s [3];
  logic [2:0]  s_cyc, s_stb, s_en, s_both, s_spur, s_ack_q;
  logic [31:0] s_adr0, s_wdat0;
  logic [2:0]  fx_req, fx_gnt;
  logic        fx_take;

  exp_t exp_q [$];
  exp_t mon_e;
  row_t tbl [8];
  int   n_cmp = 0, n_bad = 0;

  wb_interconnect_arb #(.NUMM(3), .NUMS(3), .ARB_MODE(RR), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .wbm (wbm_if),
    .wbs (wbs_if)
  );

  wb_rr_arbiter #(.NUMM(3)) u_fx (
    .clk  (clk),
    .rst  (rst),
    .mode (FIXED),
    .req  (fx_req),
    .take (fx_take),
    .gnt  (fx_gnt)
  );

  for (genvar g = 0; g < 3; g++) begin : g_glue
    assign wbm_if[g].cyc   = m_cyc[g];
    assign wbm_if[g].stb   = m_stb[g];
    assign wbm_if[g].we    = m_we[g];
    assign wbm_if[g].sel   = m_sel[g];
    assign wbm_if[g].adr   = m_adr[g];
    assign wbm_if[g].dat_m = m_dat_m[g];
    assign m_ack[g]        = wbm_if[g].ack;
    assign m_err[g]        = wbm_if[g].err;
    assign m_dat_s[g]      = wbm_if[g].dat_s;
    assign wbs_if[g].ack   = s_ack_q[g] | s_spur[g];
    assign wbs_if[g].err   = s_ack_q[g] & s_both[g];
    assign wbs_if[g].dat_s = SDAT[g];
    assign s_cyc[g]        = wbs_if[g].cyc;
    assign s_stb[g]        = wbs_if[g].stb;
  end
  assign s_adr0  = wbs_if[0].adr;
  assign s_wdat0 = wbs_if[0].dat_m;

  // registered-ack slaves
  always @(posedge clk) begin
    if (rst) s_ack_q <= '0;
    else     s_ack_q <= s_cyc & s_stb & ~s_ack_q & s_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int m, input logic err, input logic [31:0] dat);
    exp_t e;
    e.m = m; e.err = err; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic xfer(input int m, input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [2:0] exp_sc, input int exp_lat);
    int lat;
    bit got;
    @(posedge clk); #1;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr;  m_dat_m[m] = wdat; m_sel[m] = 4'hF;
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (m_ack[m] | m_err[m]) begin
        got = 1'b1;
        chk("slave_cyc", 32'(s_cyc), 32'(exp_sc));
        chk("slave_adr", s_adr0, adr);
        chk("slave_wdat", s_wdat0, wdat);
        if (exp_lat != 0) chk("latency", 32'(lat), 32'(exp_lat));
      end
    end
    chk("xfer_done", 32'(got), 32'd1);
    @(posedge clk); #1;
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (m_ack[i] | m_err[i]) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 32'(m_ack[i] | m_err[i]), 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("resp_master", 32'(i), 32'(mon_e.m));
          chk("resp_err", 32'(m_err[i]), 32'(mon_e.err));
          chk("ack_and_err", 32'(m_ack[i] & m_err[i]), 32'd0);
          if (!mon_e.err) chk("resp_dat", m_dat_s[i], mon_e.dat);
        end
      end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0;
    s_en = 3'b111; s_both = '0; s_spur = '0; fx_req = '0; fx_take = 1'b0;
    for (int i = 0; i < 3; i++) begin m_adr[i] = '0; m_dat_m[i] = '0; m_sel[i] = '0; end
    tbl = '{'{1, 32'h1000_0004, 1'b0, 3'b100, 1'b0, 32'hA5A5_A5A5},
            '{2, 32'h2000_0000, 1'b1, 3'b000, 1'b1, 32'h0},
            '{0, 32'h0000_0100, 1'b1, 3'b010, 1'b0, 32'h2222_0000},
            '{0, 32'h1A11_0FFF, 1'b0, 3'b001, 1'b0, 32'h1111_0000},
            '{1, 32'h1A11_1000, 1'b0, 3'b000, 1'b1, 32'h0},
            '{2, 32'h0000_FFFF, 1'b0, 3'b010, 1'b0, 32'h2222_0000},
            '{2, 32'h0001_0000, 1'b0, 3'b000, 1'b1, 32'h0},
            '{1, 32'h1000_0FFF, 1'b0, 3'b100, 1'b0, 32'hA5A5_A5A5}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_slave_cyc", 32'(s_cyc), 32'd0);
    chk("rst_master_resp", 32'(m_ack | m_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // fixed-priority arbiter ignores round-robin history
    fx_req = 3'b110;
    @(negedge clk) chk("fixed_gnt_a", 32'(fx_gnt), 32'b010);
    @(posedge clk); #1 fx_take = 1'b1;
    @(posedge clk); #1 fx_take = 1'b0; fx_req = 3'b111;
    @(negedge clk) chk("fixed_gnt_b", 32'(fx_gnt), 32'b001);
    fx_req = '0;

    // decode table: hits, misses, region edges
    foreach (tbl[r]) begin
      push(tbl[r].m, tbl[r].err, tbl[r].dat);
      xfer(tbl[r].m, tbl[r].adr, tbl[r].we, 32'hC0DE_0000 + 32'(r), tbl[r].sc, 3);
    end

    // simultaneous ack+err from a slave forwards err only
    s_both[0] = 1'b1;
    push(0, 1'b1, 32'h0);
    xfer(0, 32'h1A11_0010, 1'b0, 32'h0, 3'b001, 3);
    s_both[0] = 1'b0;

    // slave ack while master stb is low is dropped
    @(posedge clk); #1 m_cyc[1] = 1'b1; m_stb[1] = 1'b0; m_adr[1] = 32'h1000_0000;
    repeat (2) @(negedge clk);
    chk("nostb_slave_cyc", 32'(s_cyc), 32'b100);
    chk("nostb_slave_stb", 32'(s_stb), 32'd0);
    @(posedge clk); #1 s_spur[2] = 1'b1;
    @(negedge clk) chk("nostb_master_resp", 32'(m_ack | m_err), 32'd0);
    @(posedge clk); #1 s_spur[2] = 1'b0; m_cyc[1] = 1'b0;

    s_en[1] = 1'b0;
`ifdef WB_ICON_TIMEOUT_EN
    push(0, 1'b1, 32'h0);
    xfer(0, 32'h0000_0040, 1'b0, 32'h0, 3'b010, 18);
`endif

    // silent slave: stb held, then master abandons the cycle
    @(posedge clk); #1 m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h0;
    repeat (4) @(negedge clk);
    chk("hold_slave_stb", 32'(s_stb), 32'b010);
`ifndef WB_ICON_TIMEOUT_EN
    repeat (1000) @(negedge clk);
    chk("hold1000_slave_stb", 32'(s_stb), 32'b010);
    chk("hold1000_master_resp", 32'(m_ack | m_err), 32'd0);
`endif
    @(posedge clk); #1 m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_spur[1] = 1'b1;
    @(negedge clk);
    chk("drop_slave_cyc", 32'(s_cyc), 32'd0);
    chk("drop_master_resp", 32'(m_ack | m_err), 32'd0);
    @(posedge clk); #1 s_spur[1] = 1'b0;

    // reset while m0 waits; m0 must win next despite being last granted
    @(posedge clk); #1 m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_slave_cyc", 32'(s_cyc), 32'd0);
    chk("rstmid_master_resp", 32'(m_ack | m_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    push(0, 1'b0, 32'hA5A5_A5A5);
    push(1, 1'b0, 32'hA5A5_A5A5);
    fork
      xfer(0, 32'h1000_0010, 1'b0, 32'h0, 3'b100, 3);
      xfer(1, 32'h1000_0014, 1'b0, 32'h0, 3'b100, 7);
    join

    // m0 and m2 together: m2 follows after m0 releases plus an idle cycle
    pulse_rst();
    push(0, 1'b0, 32'hA5A5_A5A5);
    push(2, 1'b0, 32'hA5A5_A5A5);
    fork
      xfer(0, 32'h1000_0000, 1'b0, 32'h0, 3'b100, 3);
      xfer(2, 32'h1000_0008, 1'b1, 32'h55, 3'b100, 7);
    join

    // round-robin with all three requesting: 0,1,2,0
    pulse_rst();
    push(0, 1'b0, 32'hA5A5_A5A5);
    push(1, 1'b0, 32'hA5A5_A5A5);
    push(2, 1'b0, 32'hA5A5_A5A5);
    push(0, 1'b0, 32'hA5A5_A5A5);
    fork
      begin
        xfer(0, 32'h1000_0020, 1'b0, 32'h0, 3'b100, 0);
        xfer(0, 32'h1000_0024, 1'b0, 32'h0, 3'b100, 0);
      end
      xfer(1, 32'h1000_0028, 1'b0, 32'h0, 3'b100, 0);
      xfer(2, 32'h1000_002C, 1'b0, 32'h0, 3'b100, 0);
    join

    repeat (3) @(posedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
